// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: default geometry and the
// 2-bit direction counter encodings.
package bp_pkg;

   localparam int DEFAULT_ENTRIES = 16;
   localparam int DEFAULT_CNT_W   = 2;

   typedef enum logic [1:0] {
      CNT_SNT = 2'd0,
      CNT_WNT = 2'd1,
      CNT_WT  = 2'd2,
      CNT_ST  = 2'd3
   } cnt2_e;

endpackage

// File: rtl/sat_counter.sv
// Next-state logic for one saturating up/down direction counter.
module sat_counter #(
   parameter int CNT_W = bp_pkg::DEFAULT_CNT_W
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt_next
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MIN = '0;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   always_comb begin
      cnt_next = cnt;
      if (inc) begin
         if (cnt != CNT_MAX) cnt_next = cnt + CNT_ONE;
      end else begin
         if (cnt != CNT_MIN) cnt_next = cnt - CNT_ONE;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, combinational lookup and a saturating mispredict counter.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES = DEFAULT_ENTRIES,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] lookup_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        update_en,
   input  logic [31:0] update_pc,
   input  logic        update_taken,
   input  logic [31:0] update_target,
   input  logic        update_is_jump,
   input  logic        update_mispredict,
   input  logic        clear,
   output logic [15:0] mispredict_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(1) << (CNT_W - 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = '1;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [CNT_W-1:0] cnt_q    [ENTRIES];
   logic             jump_q   [ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic [CNT_W-1:0] up_cnt_next;
   logic             unused_pc_bits;

   assign lk_idx = lookup_pc[IDX_W+1:2];
   assign lk_tag = lookup_pc[31:IDX_W+2];
   assign up_idx = update_pc[IDX_W+1:2];
   assign up_tag = update_pc[31:IDX_W+2];

   // Word alignment bits never distinguish entries.
   assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

   // Lookup reads the registered table only, so a same-cycle update is not visible.
   always_comb begin
      pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken  = pred_hit && (jump_q[lk_idx] || cnt_q[lk_idx][CNT_W-1]);
      pred_target = pred_taken ? target_q[lk_idx] : (lookup_pc + 32'd4);
   end

   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
      .cnt      (cnt_q[up_idx]),
      .inc      (update_taken),
      .cnt_next (up_cnt_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= '0;
            jump_q[i]   <= 1'b0;
         end
      end else if (clear) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (update_en) begin
         if (up_hit) begin
            cnt_q[up_idx]  <= up_cnt_next;
            jump_q[up_idx] <= update_is_jump;
            if (update_taken) target_q[up_idx] <= update_target;
         end else if (update_taken) begin
            // Allocation replaces whatever occupied this index.
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= update_target;
            cnt_q[up_idx]    <= update_is_jump ? CNT_FULL : CNT_WEAK_T;
            jump_q[up_idx]   <= update_is_jump;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict_cnt <= 16'h0000;
      end else if (update_en && update_mispredict && (mispredict_cnt != 16'hFFFF)) begin
         mispredict_cnt <= mispredict_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, CNT_W=2).
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] lookup_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        update_en;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_is_jump;
   logic        update_mispredict;
   logic        clear;
   logic [15:0] mispredict_cnt;

   int tests_run;
   int tests_failed;

   branch_predictor #(.ENTRIES(16), .CNT_W(2)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .lookup_pc         (lookup_pc),
      .pred_hit          (pred_hit),
      .pred_taken        (pred_taken),
      .pred_target       (pred_target),
      .update_en         (update_en),
      .update_pc         (update_pc),
      .update_taken      (update_taken),
      .update_target     (update_target),
      .update_is_jump    (update_is_jump),
      .update_mispredict (update_mispredict),
      .clear             (clear),
      .mispredict_cnt    (mispredict_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_update(input logic [31:0] pc, input logic taken,
                            input logic [31:0] target, input logic is_jump,
                            input logic mis);
      update_en         = 1'b1;
      update_pc         = pc;
      update_taken      = taken;
      update_target     = target;
      update_is_jump    = is_jump;
      update_mispredict = mis;
      tick();
      update_en         = 1'b0;
      update_mispredict = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic set_lookup(input logic [31:0] pc);
      lookup_pc = pc;
      #1;
   endtask

   // scenarios
   task automatic test_reset();
      set_lookup(32'h0000_0040);
      tests_run++;
      if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
         tests_failed++;
         $display("FAIL reset_in_reset: hit=%b taken=%b target=%h, want 0 0 00000044",
                  pred_hit, pred_taken, pred_target);
      end
      tests_run++;
      if (mispredict_cnt !== 16'h0) begin
         tests_failed++;
         $display("FAIL reset_cnt: got %h want 0000", mispredict_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      set_lookup(32'h0000_0040);
      tests_run++;
      if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
         tests_failed++;
         $display("FAIL reset_after: hit=%b taken=%b target=%h, want 0 0 00000044",
                  pred_hit, pred_taken, pred_target);
      end
   endtask

   task automatic test_alloc_predict();
      do_update(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      set_lookup(32'h40);
      tests_run++;
      if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h100) begin
         tests_failed++;
         $display("FAIL alloc_lookup: hit=%b taken=%b target=%h, want 1 1 00000100",
                  pred_hit, pred_taken, pred_target);
      end
      do_update(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      set_lookup(32'h40);
      tests_run++;
      if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
         tests_failed++;
         $display("FAIL alloc_not_taken: hit=%b taken=%b target=%h, want 1 0 00000044",
                  pred_hit, pred_taken, pred_target);
      end
      do_update(32'h1040, 1'b0, 32'h0, 1'b0, 1'b0);
      set_lookup(32'h1040);
      tests_run++;
      if (pred_hit !== 1'b0 || pred_target !== 32'h1044) begin
         tests_failed++;
         $display("FAIL miss_not_taken_no_alloc: hit=%b target=%h, want 0 00001044",
                  pred_hit, pred_target);
      end
   endtask

   task automatic test_counter_saturation();
      do_clear();
      do_update(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      repeat (4) do_update(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      do_update(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      set_lookup(32'h40);
      tests_run++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
         tests_failed++;
         $display("FAIL cnt_sat_high: taken=%b target=%h, want 1 00000100", pred_taken, pred_target);
      end
      do_update(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      set_lookup(32'h40);
      tests_run++;
      if (pred_taken !== 1'b0) begin
         tests_failed++;
         $display("FAIL cnt_wnt: taken=%b want 0", pred_taken);
      end
      repeat (3) do_update(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      do_update(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      set_lookup(32'h40);
      tests_run++;
      if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
         tests_failed++;
         $display("FAIL cnt_no_underflow: hit=%b taken=%b target=%h, want 1 0 00000044",
                  pred_hit, pred_taken, pred_target);
      end
      do_update(32'h40, 1'b1, 32'h180, 1'b0, 1'b0);
      set_lookup(32'h40);
      tests_run++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h180) begin
         tests_failed++;
         $display("FAIL cnt_recover: taken=%b target=%h, want 1 00000180", pred_taken, pred_target);
      end
   endtask

   task automatic test_jump();
      do_update(32'h48, 1'b1, 32'h300, 1'b1, 1'b0);
      do_update(32'h48, 1'b0, 32'h0, 1'b1, 1'b0);
      do_update(32'h48, 1'b0, 32'h0, 1'b1, 1'b0);
      set_lookup(32'h48);
      tests_run++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
         tests_failed++;
         $display("FAIL jump_flag: taken=%b target=%h, want 1 00000300", pred_taken, pred_target);
      end
      do_update(32'h48, 1'b0, 32'h0, 1'b0, 1'b0);
      set_lookup(32'h48);
      tests_run++;
      if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h4C) begin
         tests_failed++;
         $display("FAIL jump_cleared: hit=%b taken=%b target=%h, want 1 0 0000004c",
                  pred_hit, pred_taken, pred_target);
      end
   endtask

   task automatic test_alias();
      do_clear();
      do_update(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      set_lookup(32'h80);
      tests_run++;
      if (pred_hit !== 1'b0 || pred_target !== 32'h84) begin
         tests_failed++;
         $display("FAIL alias_miss: hit=%b target=%h, want 0 00000084", pred_hit, pred_target);
      end
      do_update(32'h80, 1'b1, 32'h200, 1'b0, 1'b0);
      set_lookup(32'h80);
      tests_run++;
      if (pred_hit !== 1'b1 || pred_target !== 32'h200) begin
         tests_failed++;
         $display("FAIL alias_replace: hit=%b target=%h, want 1 00000200", pred_hit, pred_target);
      end
      set_lookup(32'h40);
      tests_run++;
      if (pred_hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL alias_evicted: hit=%b want 0", pred_hit);
      end
   endtask

   task automatic test_same_cycle();
      do_clear();
      do_update(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      lookup_pc     = 32'h40;
      update_en     = 1'b1;
      update_pc     = 32'h40;
      update_taken  = 1'b0;
      update_target = 32'h0;
      update_is_jump = 1'b0;
      #1;
      tests_run++;
      if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h100) begin
         tests_failed++;
         $display("FAIL same_cycle_old: hit=%b taken=%b target=%h, want 1 1 00000100",
                  pred_hit, pred_taken, pred_target);
      end
      tick();
      update_en = 1'b0;
      #1;
      tests_run++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
         tests_failed++;
         $display("FAIL same_cycle_new: taken=%b target=%h, want 0 00000044", pred_taken, pred_target);
      end
   endtask

   task automatic test_clear_priority();
      do_update(32'h44, 1'b1, 32'h500, 1'b0, 1'b0);
      clear = 1'b1;
      do_update(32'h80, 1'b1, 32'h200, 1'b0, 1'b0);
      clear = 1'b0;
      set_lookup(32'h80);
      tests_run++;
      if (pred_hit !== 1'b0 || pred_target !== 32'h84) begin
         tests_failed++;
         $display("FAIL clear_prio_upd: hit=%b target=%h, want 0 00000084", pred_hit, pred_target);
      end
      set_lookup(32'h44);
      tests_run++;
      if (pred_hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL clear_other: hit=%b want 0", pred_hit);
      end
   endtask

   task automatic test_mispredict();
      update_mispredict = 1'b1;
      tick();
      tick();
      update_mispredict = 1'b0;
      #1;
      tests_run++;
      if (mispredict_cnt !== 16'h0) begin
         tests_failed++;
         $display("FAIL mis_no_en: got %h want 0000", mispredict_cnt);
      end
      repeat (3) do_update(32'h2000, 1'b0, 32'h0, 1'b0, 1'b1);
      do_update(32'h2000, 1'b0, 32'h0, 1'b0, 1'b0);
      tests_run++;
      if (mispredict_cnt !== 16'd3) begin
         tests_failed++;
         $display("FAIL mis_count3: got %h want 0003", mispredict_cnt);
      end
      do_clear();
      tests_run++;
      if (mispredict_cnt !== 16'd3) begin
         tests_failed++;
         $display("FAIL mis_clear_keep: got %h want 0003", mispredict_cnt);
      end
      update_en         = 1'b1;
      update_pc         = 32'h2000;
      update_taken      = 1'b0;
      update_mispredict = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      update_en         = 1'b0;
      update_mispredict = 1'b0;
      tests_run++;
      if (mispredict_cnt !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL mis_saturate: got %h want ffff", mispredict_cnt);
      end
   endtask

   task automatic test_async_reset();
      do_update(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      set_lookup(32'h40);
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h44 ||
          mispredict_cnt !== 16'h0) begin
         tests_failed++;
         $display("FAIL async_reset: hit=%b taken=%b target=%h cnt=%h, want 0 0 00000044 0000",
                  pred_hit, pred_taken, pred_target, mispredict_cnt);
      end
      do_update(32'h40, 1'b1, 32'h100, 1'b0, 1'b1);
      tests_run++;
      if (pred_hit !== 1'b0 || mispredict_cnt !== 16'h0) begin
         tests_failed++;
         $display("FAIL reset_ignores_update: hit=%b cnt=%h, want 0 0000", pred_hit, mispredict_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_update(32'h40, 1'b1, 32'h140, 1'b0, 1'b1);
      tests_run++;
      if (pred_hit !== 1'b1 || pred_target !== 32'h140 || mispredict_cnt !== 16'd1) begin
         tests_failed++;
         $display("FAIL reset_release: hit=%b target=%h cnt=%h, want 1 00000140 0001",
                  pred_hit, pred_target, mispredict_cnt);
      end
   endtask

   initial begin
      tests_run         = 0;
      tests_failed      = 0;
      rst_n             = 1'b0;
      lookup_pc         = 32'h0;
      update_en         = 1'b0;
      update_pc         = 32'h0;
      update_taken      = 1'b0;
      update_target     = 32'h0;
      update_is_jump    = 1'b0;
      update_mispredict = 1'b0;
      clear             = 1'b0;
      #2;
      test_reset();
      test_alloc_predict();
      test_counter_saturation();
      test_jump();
      test_alias();
      test_same_cycle();
      test_clear_priority();
      test_mispredict();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
